core_seq_ctrl: RTL and testbench
================================

# core_seq_ctrl

Hardware sequencer that generates the 34-bit `inst` word for `core`. It replaces the hand-written per-kij stimulus loop with an FSM that runs the full weight-stationary convolution pass for all kij. Phases per kij are core reset, weight to IFIFO, kernel load, drain, activation to L0, execute, and OFIFO drain to psum memory. It sits between the host/top-level controller (start/done) and `core` (inst, ofifo_valid, reset).

## Interface
Parameters:
- `row`, 8, PE rows (input channels)
- `col`, 8, PE columns (output channels)
- `len_nij`, 36, input pixels per tile (6x6)
- `len_kij`, 9, kernel positions (3x3)
- `W_BASE`, 11'h400, xmem base address of the weight region
- `RST_CYC`, 11, core-reset cycles per kij

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `start` in 1: one-cycle request; sampled only in IDLE
- `ofifo_valid` in 1: from `core`
- `inst` out 34: to `core.inst`. Field map:
  - [33] acc
  - [32] CEN_pmem
  - [31] WEN_pmem
  - [30:20] A_pmem
  - [19] CEN_xmem
  - [18] WEN_xmem
  - [17:7] A_xmem
  - [6] ofifo_rd
  - [5] ififo_wr
  - [4] ififo_rd
  - [3] l0_rd
  - [2] l0_wr
  - [1] execute
  - [0] load
- `core_rst` out 1: reset to `core`
- `busy` out 1: sequence in progress
- `done` out 1: one-cycle completion pulse
- `kij` out 4: current kernel index

## Operation
- **Outputs and reset**
  - All outputs are flops.
  - IDLE word `IDLE_INST` = 34'h1_800C_0000: CEN/WEN high, everything else 0.
  - Reset values: `inst` = IDLE_INST, `core_rst` = 0, `busy` = 0, `done` = 0, `kij` = 0.
- **FSM states and per-cycle content** (t = cycle index within the phase):
  - CRST: RST_CYC cycles; `core_rst` = 1; `inst` = IDLE_INST.
  - WL0: 2*col+1 cycles; ififo_wr = 1, CEN_xmem = 0, WEN_xmem = 1, A_xmem = W_BASE + kij*2*col + t.
  - KLOAD: row+col cycles; ififo_rd = 1, load = 1, CEN_xmem = 1.
  - KDRAIN: 11 cycles; load = 1, ififo_rd = 0.
  - ACTL0: 2*len_nij+1 cycles; l0_wr = 1, CEN_xmem = 0, WEN_xmem = 1, A_xmem = t.
  - EXEC: 2*len_nij+row+col cycles; l0_rd = 1, execute = 1.
  - OFRD: len_nij cycles; ofifo_rd = 1, CEN_pmem = 0, WEN_pmem = 0, A_pmem = len_nij*kij + t.
  - GAP: 1 cycle; IDLE_INST.
- **Transitions**
  - GAP → CRST with `kij`+1 while kij < len_kij-1.
  - Otherwise GAP → IDLE, pulsing `done`.
- **Arithmetic**
  - Address arithmetic is 11-bit unsigned and wraps modulo 2^11; no saturation.
  - Phase counter is 8 bits, sized for the longest phase (EXEC = 88).
- **Boundary conditions**
  - `start` while busy is ignored.
  - `start` in the same cycle as `done` is ignored; a new start is accepted the next cycle.
  - `acc` is always 0; accumulation is outside this block.

## Timing
- **Start and busy**
  - Schedule cycle 0 is the cycle after the edge that samples `start`.
  - `busy` is high from cycle 0 through the final GAP cycle.
- **Cycle counts** (defaults)
  - Per kij: 11+17+16+11+73+88+36+1 = 253 cycles.
  - Full pass: 9*253 = 2277 cycles.
- **Completion**
  - `done` = 1 and `busy` = 0 in cycle 2277.
  - `inst` = IDLE_INST from that cycle.
- **Reset mid-operation**
  - Asynchronous `reset` forces IDLE immediately, with `inst` = IDLE_INST and `core_rst` = 0.
  - No completion pulse.

## Configuration
- `CORE_SEQ_OFIFO_WAIT_EN`, defined:
  - In OFRD, a cycle with `ofifo_valid` = 0 emits IDLE_INST and holds the counter; no A_pmem advance.
  - The phase completes after len_nij valid reads.
- Undefined: OFRD is a fixed len_nij cycles and `ofifo_valid` is ignored.

## Structure
- Package `core_seq_pkg` holds:
  - the state enum;
  - inst field bit positions;
  - IDLE_INST;
  - phase-length localparams derived from row/col/len_nij.
- Sub-module `core_seq_inst_pack`: combinational packer from control fields to the 34-bit word.
- Registering happens in the top-level FSM.

## Test plan
- Reset asserted → `inst` = 34'h1_800C_0000, busy = 0, done = 0, core_rst = 0, kij = 0.
- Start pulse:
  - core_rst = 1 for cycles 0–10.
  - Cycle 11: ififo_wr = 1, CEN_xmem = 0, A_xmem = 11'h400.
  - Cycle 27: A_xmem = 11'h410.
  - Cycle 28: load = 1, ififo_rd = 1.
- Second kij (cycle 253+11): A_xmem = 11'h410. Its OFRD A_pmem runs 36..71.
- Full run:
  - done pulses in cycle 2277.
  - Exactly 324 ofifo_rd cycles, covering A_pmem 0..323.
  - 9 core_rst bursts.
  - A second start accepted at cycle 2278.
- Reset in EXEC (cycle 150) → IDLE_INST in the same cycle, busy = 0, no done. A later start restarts from kij = 0.
- With CORE_SEQ_OFIFO_WAIT_EN: ofifo_valid low for 5 cycles in the first OFRD → ofifo_rd = 0 and A_pmem held during those cycles; done at cycle 2282.

Source files
------------

// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared states, inst field positions, idle word and phase lengths for core_seq_ctrl
package core_seq_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_CRST, S_WL0, S_KLOAD, S_KDRAIN, S_ACTL0, S_EXEC, S_OFRD, S_GAP
  } state_t;
  localparam int ACC_B      = 33;
  localparam int CEN_PMEM_B = 32;
  localparam int WEN_PMEM_B = 31;
  localparam int A_PMEM_L   = 20;
  localparam int CEN_XMEM_B = 19;
  localparam int WEN_XMEM_B = 18;
  localparam int A_XMEM_L   = 7;
  localparam int OFIFO_RD_B = 6;
  localparam int IFIFO_WR_B = 5;
  localparam int IFIFO_RD_B = 4;
  localparam int L0_RD_B    = 3;
  localparam int L0_WR_B    = 2;
  localparam int EXECUTE_B  = 1;
  localparam int LOAD_B     = 0;
  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;
  localparam int DEF_ROW     = 8;
  localparam int DEF_COL     = 8;
  localparam int DEF_LEN_NIJ = 36;
  localparam int DEF_LEN_KIJ = 9;
  localparam int DEF_RST_CYC = 11;
  localparam int KDRAIN_LEN  = 11;
  function automatic logic [7:0] phase_len(state_t s, int row, int col, int len_nij, int rst_cyc);
    case (s)
      S_CRST:   return 8'(rst_cyc);
      S_WL0:    return 8'(2 * col + 1);
      S_KLOAD:  return 8'(row + col);
      S_KDRAIN: return 8'(KDRAIN_LEN);
      S_ACTL0:  return 8'(2 * len_nij + 1);
      S_EXEC:   return 8'(2 * len_nij + row + col);
      S_OFRD:   return 8'(len_nij);
      default:  return 8'd1;
    endcase
  endfunction
endpackage

// File: rtl/core_seq_inst_pack.sv
// core_seq_inst_pack: packs control fields into the 34-bit core inst word (fields in, inst out)
module core_seq_inst_pack
  import core_seq_pkg::*;
(
  input  logic        acc,
  input  logic        cen_p,
  input  logic        wen_p,
  input  logic [10:0] a_p,
  input  logic        cen_x,
  input  logic        wen_x,
  input  logic [10:0] a_x,
  input  logic        ofifo_rd,
  input  logic        ififo_wr,
  input  logic        ififo_rd,
  input  logic        l0_rd,
  input  logic        l0_wr,
  input  logic        execute,
  input  logic        load,
  output logic [33:0] inst
);
  always_comb begin
    inst = '0;
    inst[ACC_B] = acc;
    inst[CEN_PMEM_B] = cen_p;
    inst[WEN_PMEM_B] = wen_p;
    inst[A_PMEM_L +: 11] = a_p;
    inst[CEN_XMEM_B] = cen_x;
    inst[WEN_XMEM_B] = wen_x;
    inst[A_XMEM_L +: 11] = a_x;
    inst[OFIFO_RD_B] = ofifo_rd;
    inst[IFIFO_WR_B] = ififo_wr;
    inst[IFIFO_RD_B] = ififo_rd;
    inst[L0_RD_B] = l0_rd;
    inst[L0_WR_B] = l0_wr;
    inst[EXECUTE_B] = execute;
    inst[LOAD_B] = load;
  end
endmodule

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: sequences all kij phases of a weight-stationary pass; ports clk, reset (async), start, ofifo_valid in; inst[33:0], core_rst, busy, done, kij[3:0] out; CORE_SEQ_OFIFO_WAIT_EN stalls OFRD on ofifo_valid
module core_seq_ctrl
  import core_seq_pkg::*;
#(
  parameter int          row     = DEF_ROW,
  parameter int          col     = DEF_COL,
  parameter int          len_nij = DEF_LEN_NIJ,
  parameter int          len_kij = DEF_LEN_KIJ,
  parameter logic [10:0] W_BASE  = 11'h400,
  parameter int          RST_CYC = DEF_RST_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij
);
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] kij_n;
  logic done_n, crst_n, adv, rd, last;
  logic cen_p, wen_p, cen_x, wen_x, ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, execute, load;
  logic [10:0] a_p, a_x;
  logic [33:0] inst_n;
`ifdef CORE_SEQ_OFIFO_WAIT_EN
  // a held OFRD cycle (no read issued) does not advance the read count
  assign adv = state != S_OFRD || inst[OFIFO_RD_B];
  assign rd  = ofifo_valid;
`else
  logic unused_ofifo_valid;
  assign unused_ofifo_valid = ofifo_valid;
  assign adv = 1'b1;
  assign rd  = 1'b1;
`endif
  assign last = adv && cnt == phase_len(state, row, col, len_nij, RST_CYC) - 8'd1;
  // outputs are registered from the next-cycle state so cycle 0 follows the start edge
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    kij_n = kij;
    done_n = 1'b0;
    if (state == S_IDLE) begin
      if (start && !done) begin
        state_n = S_CRST;
        cnt_n = '0;
        kij_n = '0;
      end
    end else if (state == S_GAP) begin
      cnt_n = '0;
      if (kij < 4'(len_kij - 1)) begin
        state_n = S_CRST;
        kij_n = kij + 4'd1;
      end else begin
        state_n = S_IDLE;
        done_n = 1'b1;
      end
    end else if (last) begin
      state_n = state_t'(state + 4'd1);
      cnt_n = '0;
    end else if (adv) cnt_n = cnt + 8'd1;
    crst_n = state_n == S_CRST;
    cen_p = 1'b1;
    wen_p = 1'b1;
    a_p = '0;
    cen_x = 1'b1;
    wen_x = 1'b1;
    a_x = '0;
    ofifo_rd = 1'b0;
    ififo_wr = 1'b0;
    ififo_rd = 1'b0;
    l0_rd = 1'b0;
    l0_wr = 1'b0;
    execute = 1'b0;
    load = 1'b0;
    case (state_n)
      S_WL0: begin
        ififo_wr = 1'b1;
        cen_x = 1'b0;
        a_x = W_BASE + 11'(kij_n * 2 * col) + 11'(cnt_n);
      end
      S_KLOAD: begin
        ififo_rd = 1'b1;
        load = 1'b1;
      end
      S_KDRAIN: load = 1'b1;
      S_ACTL0: begin
        l0_wr = 1'b1;
        cen_x = 1'b0;
        a_x = 11'(cnt_n);
      end
      S_EXEC: begin
        l0_rd = 1'b1;
        execute = 1'b1;
      end
      S_OFRD: begin
        ofifo_rd = rd;
        cen_p = !rd;
        wen_p = !rd;
        a_p = rd ? 11'(len_nij * kij_n) + 11'(cnt_n) : 11'd0;
      end
      default: ;
    endcase
  end
  core_seq_inst_pack u_pack (
    .acc(1'b0), .cen_p(cen_p), .wen_p(wen_p), .a_p(a_p), .cen_x(cen_x), .wen_x(wen_x), .a_x(a_x),
    .ofifo_rd(ofifo_rd), .ififo_wr(ififo_wr), .ififo_rd(ififo_rd), .l0_rd(l0_rd), .l0_wr(l0_wr),
    .execute(execute), .load(load), .inst(inst_n)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      kij <= '0;
      inst <= IDLE_INST;
      core_rst <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      kij <= kij_n;
      inst <= inst_n;
      core_rst <= crst_n;
      busy <= state_n != S_IDLE;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl: directed self-checking bench for core_seq_ctrl
module tb_core_seq_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic ofifo_valid = 1'b1;
  logic [33:0] inst;
  logic core_rst, busy, done;
  logic [3:0] kij;
  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
`ifdef CORE_SEQ_OFIFO_WAIT_EN
  localparam int END = 2282;
`else
  localparam int END = 2277;
`endif
  int checks = 0;
  int errors = 0;
  int nrd, bad_addr, bursts, acc_bad, done_cyc, done_seen;
  logic prev_crst;
  core_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .core_rst(core_rst), .busy(busy), .done(done), .kij(kij)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst inst", 64'(inst), 64'(IDLE_W));
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst core_rst", 64'(core_rst), 64'd0);
    check("rst kij", 64'(kij), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    nrd = 0; bad_addr = 0; bursts = 0; acc_bad = 0; done_cyc = -1; prev_crst = 1'b0;
    for (int c = 0; c <= END; c++) begin
      if (c > 0) @(negedge clk);
`ifdef CORE_SEQ_OFIFO_WAIT_EN
      if (c == 216) ofifo_valid = 1'b0;
      if (c == 221) ofifo_valid = 1'b1;
      if (c >= 217 && c <= 221) check("ofrd hold idle", 64'(inst), 64'(IDLE_W));
      if (c == 222) check("ofrd resume", 64'({inst[6], inst[30:20]}), 64'({1'b1, 11'd1}));
`endif
      if (c == 0) check("c0 core_rst", 64'(core_rst), 64'd1);
      if (c == 0) check("c0 busy", 64'(busy), 64'd1);
      if (c == 10) check("c10 core_rst", 64'(core_rst), 64'd1);
      if (c == 11) check("c11 core_rst", 64'(core_rst), 64'd0);
      if (c == 11) check("c11 wl0", 64'({inst[5], inst[19], inst[18], inst[17:7]}), 64'({3'b101, 11'h400}));
      if (c == 27) check("c27 a_xmem", 64'({inst[5], inst[17:7]}), 64'({1'b1, 11'h410}));
      if (c == 28) check("c28 kload", 64'({inst[5], inst[4], inst[0]}), 64'(3'b011));
      if (c == 264) check("kij1 a_xmem", 64'(inst[17:7]), 64'(11'h410));
      if (c == 264) check("kij1 kij", 64'(kij), 64'd1);
      if (c == END - 1) check("pre-done busy", 64'({busy, done}), 64'(2'b10));
      if (inst[33]) acc_bad++;
      if (core_rst && !prev_crst) bursts++;
      prev_crst = core_rst;
      if (inst[6]) begin
        if (inst[30:20] != 11'(nrd) || inst[32:31] != 2'b00) bad_addr++;
        nrd++;
      end
      if (done && done_cyc < 0) done_cyc = c;
    end
    check("end done", 64'(done), 64'd1);
    check("end busy", 64'(busy), 64'd0);
    check("end inst", 64'(inst), 64'(IDLE_W));
    check("done cycle", 64'(done_cyc), 64'(END));
    check("ofifo_rd count", 64'(nrd), 64'd324);
    check("pmem addr errs", 64'(bad_addr), 64'd0);
    check("core_rst bursts", 64'(bursts), 64'd9);
    check("acc set", 64'(acc_bad), 64'd0);
    pulse_start();
    check("start on done ignored", 64'({busy, core_rst}), 64'd0);
    pulse_start();
    check("restart busy", 64'(busy), 64'd1);
    check("restart crst", 64'(core_rst), 64'd1);
    check("restart kij", 64'(kij), 64'd0);
    repeat (150) @(negedge clk);
    check("c150 exec", 64'({inst[3], inst[1]}), 64'(2'b11));
    reset = 1'b1;
    #1;
    check("async rst inst", 64'(inst), 64'(IDLE_W));
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst crst", 64'(core_rst), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("no done after rst", 64'(done_seen), 64'd0);
    pulse_start();
    check("post-rst kij", 64'(kij), 64'd0);
    check("post-rst crst", 64'(core_rst), 64'd1);
    repeat (11) @(negedge clk);
    check("post-rst a_xmem", 64'({inst[5], inst[17:7]}), 64'({1'b1, 11'h400}));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
